// File: rtl/fp_div_result_queue.sv
// Result FIFO behind the floating-point divider: buffers {z, status} with a
// valid/ready handshake and keeps sticky exception flags plus a saturating exception count.
module fp_div_result_queue #(
  parameter int sig_width = 23,
  parameter int exp_width = 8,
  parameter int depth     = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [sig_width+exp_width:0] in_z,
  input  logic [7:0]                   in_status,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [sig_width+exp_width:0] out_z,
  output logic [7:0]                   out_status,
  output logic [$clog2(depth):0]       count,
  input  logic                         flags_clr,
  output logic [4:0]                   sticky_flags,
  output logic [15:0]                  exc_count
);

  localparam int isize = sig_width + exp_width + 1;
  localparam int aw    = $clog2(depth);
  localparam int ew    = isize + 8;
  localparam logic [aw:0]   full_count = (aw+1)'(depth);
  localparam logic [15:0]   exc_max    = 16'hFFFF;

  generate
    if (depth < 2 || (depth & (depth - 1)) != 0) begin : g_bad_depth
      $error("fp_div_result_queue: depth must be a power of 2 and at least 2");
    end
  endgenerate

  logic [aw-1:0] wr_ptr_reg, wr_ptr_next;
  logic [aw-1:0] rd_ptr_reg, rd_ptr_next;
  logic [aw:0]   count_reg, count_next;
  logic [4:0]    sticky_reg, sticky_next;
  logic [15:0]   exc_count_reg, exc_count_next;
  logic [ew-1:0] mem_reg [depth];
  logic [depth-1:0] wr_en;
  logic [ew-1:0] head;
  logic          push, pop;
  logic [4:0]    mapped_flags;
  logic          exc_hit;

  // Handshake depends only on the registered occupancy.
  assign in_ready  = (count_reg != full_count);
  assign out_valid = (count_reg != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign head       = mem_reg[rd_ptr_reg];
  assign out_z      = head[ew-1:8];
  assign out_status = head[7:0] & 8'hBF;
  assign count        = count_reg;
  assign sticky_flags = sticky_reg;
  assign exc_count    = exc_count_reg;

  // Status bit map {dz, rsvd, inexact, huge, tiny, invalid, inf, zero}
  // reordered into {invalid, dz, overflow, underflow, inexact}.
  assign mapped_flags = {in_status[2], in_status[7], in_status[4], in_status[3], in_status[5]};
  assign exc_hit      = in_status[2] | in_status[7];

  genvar gi;
  generate
    for (gi = 0; gi < depth; gi++) begin : g_wr_en
      assign wr_en[gi] = push && (wr_ptr_reg == aw'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < depth; i++) begin
        mem_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < depth; i++) begin
        if (wr_en[i]) begin
          mem_reg[i] <= {in_z, in_status};
        end
      end
    end
  end

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (push) begin
      wr_ptr_next = wr_ptr_reg + aw'(1);
    end
    if (pop) begin
      rd_ptr_next = rd_ptr_reg + aw'(1);
    end
    case ({push, pop})
      2'b10:   count_next = count_reg + (aw+1)'(1);
      2'b01:   count_next = count_reg - (aw+1)'(1);
      default: count_next = count_reg;
    endcase
  end

  // Clear wins first, then the same-cycle push still contributes.
  always_comb begin
    sticky_next    = flags_clr ? 5'd0  : sticky_reg;
    exc_count_next = flags_clr ? 16'd0 : exc_count_reg;
    if (push) begin
      sticky_next = sticky_next | mapped_flags;
      if (exc_hit && exc_count_next != exc_max) begin
        exc_count_next = exc_count_next + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      sticky_reg    <= '0;
      exc_count_reg <= '0;
    end else begin
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      count_reg     <= count_next;
      sticky_reg    <= sticky_next;
      exc_count_reg <= exc_count_next;
    end
  end

endmodule
